ysyx_22040365_hazard_ctrl: RTL and testbench
============================================

YSYX_22040365_HAZARD_CTRL -- requirements
Module: ysyx_22040365_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the memory-wait cycle count at which mem_timeout_err sets.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 rs1_en_23, rs2_en_23  in  1 each  IF/ID source-operand enables.
REQ-005 rs1_addr_23, rs2_addr_23  in  5 each  IF/ID source register indices.
REQ-006 rd_en_34, rd_addr_34[4:0], is_load_34  in  1/5/1  ID/EX destination and load flag.
REQ-007 rd_en_45, rd_addr_45[4:0]  in  1/5  EX/MEM destination.
REQ-008 mem_req_45  in  1  EX/MEM instruction is accessing data memory.
REQ-009 mem_ready  in  1  data memory completes the access this cycle.
REQ-010 redirect_ex  in  1  taken branch/jump resolved in EX.
REQ-011 stall_pc, stall_23  out  1 each  hold PC and IF/ID register.
REQ-012 stall_mem_ex  out  1  hold ID/EX register, including the regfile operand latches.
REQ-013 bubble_34  out  1  load a NOP (rd_en=0) into ID/EX next edge.
REQ-014 flush_23  out  1  invalidate IF/ID next edge.
REQ-015 fwd_rs1_sel_34, fwd_rs2_sel_34  out  2 each  registered EX-stage operand source: 00 regfile, 01 MEM stage, 10 WB stage.
REQ-016 mem_timeout_err  out  1  sticky memory-timeout flag.
REQ-017 perf_stall_cnt  out  32  saturating count of cycles with stall_pc=1.

Function
REQ-018 FSM states SHALL be RUN and MEM_WAIT; reset state RUN.
REQ-019 RUN->MEM_WAIT when mem_req_45=1 and mem_ready=0; MEM_WAIT->RUN on the cycle mem_ready=1.
REQ-020 stall_mem_ex SHALL be 1 combinationally when mem_req_45=1 and mem_ready=0, in either state; 0 in the cycle mem_ready=1.
REQ-021 Whenever stall_mem_ex=1: stall_pc=stall_23=1, bubble_34=0, flush_23=0, and redirect_ex and load-use are ignored.
REQ-022 Load-use hazard SHALL be is_load_34 & rd_en_34 & rd_addr_34!=0 & ((rs1_en_23 & rs1_addr_23==rd_addr_34) | (rs2_en_23 & rs2_addr_23==rd_addr_34)).
REQ-023 Priority when stall_mem_ex=0: redirect_ex > load-use.
REQ-024 redirect_ex=1: flush_23=1, bubble_34=1, stall_pc=stall_23=0, for exactly the cycles it is asserted.
REQ-025 Load-use without redirect: stall_pc=stall_23=1, bubble_34=1, flush_23=0; self-clears the following cycle once the load moves to EX/MEM.
REQ-026 Forward select, computed per operand from the IF/ID source at the edge it enters ID/EX:
- 01 if en & addr!=0 & rd_en_34 & addr==rd_addr_34;
- else 10 if en & addr!=0 & rd_en_45 & addr==rd_addr_45;
- else 00.
REQ-027 fwd_*_sel_34 SHALL hold while stall_mem_ex=1 and load 00 on any edge where bubble_34=1.
REQ-028 A wait counter SHALL clear on entering MEM_WAIT and increment each MEM_WAIT cycle, saturating at MEM_TIMEOUT.
REQ-029 mem_timeout_err SHALL set on the edge the counter reaches MEM_TIMEOUT and stay set until reset; the FSM keeps waiting.
REQ-030 perf_stall_cnt SHALL increment by 1 per edge with stall_pc=1 and hold at 32'hFFFF_FFFF.
REQ-031 All outputs not listed as registered SHALL be combinational from state and inputs, with no latency.

Reset
REQ-032 rst=0 SHALL immediately force state RUN, fwd_*_sel_34=00, wait counter=0, mem_timeout_err=0 and perf_stall_cnt=0, without waiting for a clock edge.
REQ-033 During reset, stall_pc, stall_23, stall_mem_ex, bubble_34 and flush_23 SHALL be 0.
REQ-034 Reset deasserted mid MEM_WAIT SHALL resume in RUN; the in-flight request is re-evaluated from mem_req_45/mem_ready.

Verification
REQ-035 Load x5 in ID/EX (is_load_34=1, rd_addr_34=5), rs1_addr_23=5, rs1_en_23=1 -> one cycle stall_pc=stall_23=bubble_34=1; next edge fwd_rs1_sel_34=00; perf_stall_cnt=1.
REQ-036 rd_addr_34=7 (non-load), rs2_addr_23=7, rd_addr_45=7 -> no stall; fwd_rs2_sel_34=01 next edge. Repeat with only rd_addr_45=7 -> 10. Repeat with addr 0 -> 00.
REQ-037 mem_req_45=1 with mem_ready low for 3 cycles, then high -> stall_mem_ex=1 for 3 cycles, then 0; state back to RUN; perf_stall_cnt=3.
REQ-038 redirect_ex=1 together with a load-use match -> flush_23=1, bubble_34=1, stall_pc=0. The same inputs with mem_req_45=1 and mem_ready=0 -> only the stalls assert.
REQ-039 MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_err rises after 4 wait cycles and stays 1 after mem_ready; rst pulsed low asynchronously between edges -> all registered outputs 0 at once.

Source files
------------

// File: rtl/ysyx_22040365_hazard_ctrl.sv
// ysyx_22040365_hazard_ctrl: interlock, flush and forward-select control
// for the 5-stage pipeline, with a memory-wait watchdog and stall counter.
module ysyx_22040365_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rs1_en_23,
    input  logic        rs2_en_23,
    input  logic [4:0]  rs1_addr_23,
    input  logic [4:0]  rs2_addr_23,
    input  logic        rd_en_34,
    input  logic [4:0]  rd_addr_34,
    input  logic        is_load_34,
    input  logic        rd_en_45,
    input  logic [4:0]  rd_addr_45,
    input  logic        mem_req_45,
    input  logic        mem_ready,
    input  logic        redirect_ex,
    output logic        stall_pc,
    output logic        stall_23,
    output logic        stall_mem_ex,
    output logic        bubble_34,
    output logic        flush_23,
    output logic [1:0]  fwd_rs1_sel_34,
    output logic [1:0]  fwd_rs2_sel_34,
    output logic        mem_timeout_err,
    output logic [31:0] perf_stall_cnt
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_wait_cnt;
    logic [1:0]     r_fwd1;
    logic [1:0]     r_fwd2;
    logic           r_err;
    logic [31:0]    r_perf;

    logic           w_mem_stall;
    logic           w_lu_rs1;
    logic           w_lu_rs2;
    logic           w_load_use;
    logic           w_redirect;
    logic           w_lu_stall;
    logic [1:0]     w_fwd1;
    logic [1:0]     w_fwd2;
    logic [CW-1:0]  w_cnt_nxt;

    function automatic logic [1:0] f_sel(
        input logic       en,
        input logic [4:0] addr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (en && addr != 5'd0 && rd_en_34 && addr == rd_addr_34)
            sel = 2'b01;
        else if (en && addr != 5'd0 && rd_en_45 && addr == rd_addr_45)
            sel = 2'b10;
        return sel;
    endfunction

    // All control outputs are gated by rst so they read 0 while in reset
    assign w_mem_stall = rst & mem_req_45 & ~mem_ready;
    assign w_lu_rs1    = rs1_en_23 & (rs1_addr_23 == rd_addr_34);
    assign w_lu_rs2    = rs2_en_23 & (rs2_addr_23 == rd_addr_34);
    assign w_load_use  = rst & is_load_34 & rd_en_34
                       & (rd_addr_34 != 5'd0) & (w_lu_rs1 | w_lu_rs2);
    assign w_redirect  = rst & redirect_ex & ~w_mem_stall;
    assign w_lu_stall  = w_load_use & ~redirect_ex & ~w_mem_stall;

    assign stall_mem_ex = w_mem_stall;
    assign stall_pc     = w_mem_stall | w_lu_stall;
    assign stall_23     = w_mem_stall | w_lu_stall;
    assign bubble_34    = w_redirect | w_lu_stall;
    assign flush_23     = w_redirect;

    assign w_fwd1 = f_sel(rs1_en_23, rs1_addr_23);
    assign w_fwd2 = f_sel(rs2_en_23, rs2_addr_23);

    assign w_cnt_nxt = (r_wait_cnt == TMO) ? r_wait_cnt
                                           : r_wait_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= RUN;
                    end else begin
                        r_wait_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == TMO)
                            r_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd1 <= 2'b00;
            r_fwd2 <= 2'b00;
        end else if (!w_mem_stall) begin
            r_fwd1 <= bubble_34 ? 2'b00 : w_fwd1;
            r_fwd2 <= bubble_34 ? 2'b00 : w_fwd2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_perf <= '0;
        else if (stall_pc && r_perf != 32'hFFFF_FFFF)
            r_perf <= r_perf + 32'd1;
    end

    assign fwd_rs1_sel_34  = r_fwd1;
    assign fwd_rs2_sel_34  = r_fwd2;
    assign mem_timeout_err = r_err;
    assign perf_stall_cnt  = r_perf;

endmodule

// File: tb/tb_ysyx_22040365_hazard_ctrl.sv
// tb_ysyx_22040365_hazard_ctrl: table-driven scenarios for the hazard unit,
// expected control/forward values queued at drive time and checked on output.
module tb_ysyx_22040365_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        rs1_en_23, rs2_en_23;
    logic [4:0]  rs1_addr_23, rs2_addr_23;
    logic        rd_en_34, is_load_34;
    logic [4:0]  rd_addr_34;
    logic        rd_en_45;
    logic [4:0]  rd_addr_45;
    logic        mem_req_45, mem_ready, redirect_ex;
    logic        stall_pc, stall_23, stall_mem_ex, bubble_34, flush_23;
    logic [1:0]  fwd_rs1_sel_34, fwd_rs2_sel_34;
    logic        mem_timeout_err;
    logic [31:0] perf_stall_cnt;

    logic [4:0]  comb;
    logic [3:0]  fwd;
    assign comb = {stall_pc, stall_23, stall_mem_ex, bubble_34, flush_23};
    assign fwd  = {fwd_rs1_sel_34, fwd_rs2_sel_34};

    int n_chk;
    int n_fail;
    int exp_perf;

    logic [4:0] comb_q[$];
    logic [3:0] fwd_q[$];
    logic       err_q[$];

    typedef struct packed {
        logic       rs1_en;
        logic [4:0] rs1;
        logic       rs2_en;
        logic [4:0] rs2;
        logic       d3_en;
        logic [4:0] d3;
        logic       ld;
        logic       d4_en;
        logic [4:0] d4;
        logic       req;
        logic       rdy;
        logic       rdr;
    } stim_t;

    ysyx_22040365_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_en_23       (rs1_en_23),
        .rs2_en_23       (rs2_en_23),
        .rs1_addr_23     (rs1_addr_23),
        .rs2_addr_23     (rs2_addr_23),
        .rd_en_34        (rd_en_34),
        .rd_addr_34      (rd_addr_34),
        .is_load_34      (is_load_34),
        .rd_en_45        (rd_en_45),
        .rd_addr_45      (rd_addr_45),
        .mem_req_45      (mem_req_45),
        .mem_ready       (mem_ready),
        .redirect_ex     (redirect_ex),
        .stall_pc        (stall_pc),
        .stall_23        (stall_23),
        .stall_mem_ex    (stall_mem_ex),
        .bubble_34       (bubble_34),
        .flush_23        (flush_23),
        .fwd_rs1_sel_34  (fwd_rs1_sel_34),
        .fwd_rs2_sel_34  (fwd_rs2_sel_34),
        .mem_timeout_err (mem_timeout_err),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(
        input int r1e, input int r1, input int r2e, input int r2,
        input int d3e, input int d3, input int ld,
        input int d4e, input int d4,
        input int rq, input int rdy, input int rdr
    );
        stim_t s;
        s.rs1_en = (r1e != 0);
        s.rs1    = 5'(r1);
        s.rs2_en = (r2e != 0);
        s.rs2    = 5'(r2);
        s.d3_en  = (d3e != 0);
        s.d3     = 5'(d3);
        s.ld     = (ld != 0);
        s.d4_en  = (d4e != 0);
        s.d4     = 5'(d4);
        s.req    = (rq != 0);
        s.rdy    = (rdy != 0);
        s.rdr    = (rdr != 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rs1_en_23   = s.rs1_en;
        rs1_addr_23 = s.rs1;
        rs2_en_23   = s.rs2_en;
        rs2_addr_23 = s.rs2;
        rd_en_34    = s.d3_en;
        rd_addr_34  = s.d3;
        is_load_34  = s.ld;
        rd_en_45    = s.d4_en;
        rd_addr_45  = s.d4;
        mem_req_45  = s.req;
        mem_ready   = s.rdy;
        redirect_ex = s.rdr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        #2;
        rst = 1'b0;
        apply(mk(1,5,1,5,1,5,1,1,5,1,0,1));
        #1;
        n_chk++;
        if (comb !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_comb: got %b want 00000", comb);
        end
        n_chk++;
        if (fwd !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_fwd: got %b want 0000", fwd);
        end
        n_chk++;
        if (mem_timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 0", mem_timeout_err);
        end
        n_chk++;
        if (perf_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d want 0", perf_stall_cnt);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (fwd !== 4'b0000 || perf_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hold: fwd %b perf %0d want 0000/0",
                     fwd, perf_stall_cnt);
        end
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t      st[5];
        logic [4:0] ec[5];
        logic [3:0] ef[5];
        logic [4:0] e;
        logic [3:0] f;
        st[0] = mk(1,5, 0,0, 1,5,1, 0,0, 0,0,0); ec[0] = 5'b11010; ef[0] = 4'b0000;
        st[1] = mk(1,5, 0,0, 0,0,0, 1,5, 0,0,0); ec[1] = 5'b00000; ef[1] = 4'b1000;
        st[2] = mk(0,0, 1,9, 1,9,1, 0,0, 0,0,0); ec[2] = 5'b11010; ef[2] = 4'b0000;
        st[3] = mk(1,0, 0,0, 1,0,1, 0,0, 0,0,0); ec[3] = 5'b00000; ef[3] = 4'b0000;
        st[4] = mk(0,6, 0,0, 1,6,1, 0,0, 0,0,0); ec[4] = 5'b00000; ef[4] = 4'b0000;
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            comb_q.push_back(ec[i]);
            fwd_q.push_back(ef[i]);
            if (ec[i][4]) exp_perf++;
            #1;
            e = comb_q.pop_front();
            n_chk++;
            if (comb !== e) begin
                n_fail++;
                $display("FAIL load_use[%0d] comb: got %b want %b", i, comb, e);
            end
            @(posedge clk);
            #1;
            f = fwd_q.pop_front();
            n_chk++;
            if (fwd !== f) begin
                n_fail++;
                $display("FAIL load_use[%0d] fwd: got %b want %b", i, fwd, f);
            end
        end
        n_chk++;
        if (perf_stall_cnt !== 32'(exp_perf)) begin
            n_fail++;
            $display("FAIL load_use perf: got %0d want %0d",
                     perf_stall_cnt, exp_perf);
        end
    endtask

    task automatic test_forward();
        stim_t      st[5];
        logic [3:0] ef[5];
        logic [4:0] e;
        logic [3:0] f;
        st[0] = mk(0,0, 1,7, 1,7,0, 1,7, 0,0,0); ef[0] = 4'b0001;
        st[1] = mk(0,0, 1,7, 0,7,0, 1,7, 0,0,0); ef[1] = 4'b0010;
        st[2] = mk(0,0, 1,0, 1,0,0, 1,0, 0,0,0); ef[2] = 4'b0000;
        st[3] = mk(1,7, 0,0, 1,7,0, 1,7, 0,0,0); ef[3] = 4'b0100;
        st[4] = mk(1,3, 1,4, 1,4,0, 1,3, 0,0,0); ef[4] = 4'b1001;
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            comb_q.push_back(5'b00000);
            fwd_q.push_back(ef[i]);
            #1;
            e = comb_q.pop_front();
            n_chk++;
            if (comb !== e) begin
                n_fail++;
                $display("FAIL forward[%0d] comb: got %b want %b", i, comb, e);
            end
            @(posedge clk);
            #1;
            f = fwd_q.pop_front();
            n_chk++;
            if (fwd !== f) begin
                n_fail++;
                $display("FAIL forward[%0d] fwd: got %b want %b", i, fwd, f);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t      st[5];
        logic [4:0] ec[5];
        logic [3:0] ef[5];
        logic [4:0] e;
        logic [3:0] f;
        st[0] = mk(1,4, 0,0, 1,4,0, 0,0, 1,0,0); ec[0] = 5'b11100; ef[0] = 4'b1001;
        st[1] = st[0];                           ec[1] = 5'b11100; ef[1] = 4'b1001;
        st[2] = st[0];                           ec[2] = 5'b11100; ef[2] = 4'b1001;
        st[3] = mk(1,4, 0,0, 1,4,0, 0,0, 1,1,0); ec[3] = 5'b00000; ef[3] = 4'b0100;
        st[4] = mk(0,0, 1,2, 0,0,0, 1,2, 1,1,0); ec[4] = 5'b00000; ef[4] = 4'b0010;
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            comb_q.push_back(ec[i]);
            fwd_q.push_back(ef[i]);
            if (ec[i][4]) exp_perf++;
            #1;
            e = comb_q.pop_front();
            n_chk++;
            if (comb !== e) begin
                n_fail++;
                $display("FAIL mem_wait[%0d] comb: got %b want %b", i, comb, e);
            end
            @(posedge clk);
            #1;
            f = fwd_q.pop_front();
            n_chk++;
            if (fwd !== f) begin
                n_fail++;
                $display("FAIL mem_wait[%0d] fwd: got %b want %b", i, fwd, f);
            end
        end
        n_chk++;
        if (perf_stall_cnt !== 32'(exp_perf)) begin
            n_fail++;
            $display("FAIL mem_wait perf: got %0d want %0d",
                     perf_stall_cnt, exp_perf);
        end
        n_chk++;
        if (mem_timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_wait err: got %b want 0", mem_timeout_err);
        end
    endtask

    task automatic test_redirect();
        stim_t      st[5];
        logic [4:0] ec[5];
        logic [3:0] ef[5];
        logic [4:0] e;
        logic [3:0] f;
        st[0] = mk(1,5, 0,0, 1,5,1, 0,0, 0,0,1); ec[0] = 5'b00011; ef[0] = 4'b0000;
        st[1] = mk(1,5, 0,0, 1,5,1, 0,0, 1,0,1); ec[1] = 5'b11100; ef[1] = 4'b0000;
        st[2] = mk(1,5, 0,0, 1,5,1, 0,0, 1,1,1); ec[2] = 5'b00011; ef[2] = 4'b0000;
        st[3] = mk(0,0, 1,8, 0,0,0, 1,8, 0,0,1); ec[3] = 5'b00011; ef[3] = 4'b0000;
        st[4] = mk(0,0, 1,8, 0,0,0, 1,8, 0,0,0); ec[4] = 5'b00000; ef[4] = 4'b0010;
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            comb_q.push_back(ec[i]);
            fwd_q.push_back(ef[i]);
            if (ec[i][4]) exp_perf++;
            #1;
            e = comb_q.pop_front();
            n_chk++;
            if (comb !== e) begin
                n_fail++;
                $display("FAIL redirect[%0d] comb: got %b want %b", i, comb, e);
            end
            @(posedge clk);
            #1;
            f = fwd_q.pop_front();
            n_chk++;
            if (fwd !== f) begin
                n_fail++;
                $display("FAIL redirect[%0d] fwd: got %b want %b", i, fwd, f);
            end
        end
        n_chk++;
        if (perf_stall_cnt !== 32'(exp_perf)) begin
            n_fail++;
            $display("FAIL redirect perf: got %0d want %0d",
                     perf_stall_cnt, exp_perf);
        end
    endtask

    task automatic test_timeout();
        stim_t      st[8];
        logic [4:0] ec[8];
        logic       ee[8];
        logic [4:0] e;
        logic [3:0] f;
        logic       r;
        st[0] = mk(1,9, 0,0, 1,9,0, 0,0, 0,0,0); ec[0] = 5'b00000; ee[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            st[k] = mk(1,9, 0,0, 1,9,0, 0,0, 1,0,0);
            ec[k] = 5'b11100;
            ee[k] = (k == 5);
        end
        st[6] = mk(1,9, 0,0, 1,9,0, 0,0, 1,1,0); ec[6] = 5'b00000; ee[6] = 1'b1;
        st[7] = st[0];                           ec[7] = 5'b00000; ee[7] = 1'b1;
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            comb_q.push_back(ec[i]);
            fwd_q.push_back(4'b0100);
            err_q.push_back(ee[i]);
            if (ec[i][4]) exp_perf++;
            #1;
            e = comb_q.pop_front();
            n_chk++;
            if (comb !== e) begin
                n_fail++;
                $display("FAIL timeout[%0d] comb: got %b want %b", i, comb, e);
            end
            @(posedge clk);
            #1;
            f = fwd_q.pop_front();
            r = err_q.pop_front();
            n_chk++;
            if (fwd !== f || mem_timeout_err !== r) begin
                n_fail++;
                $display("FAIL timeout[%0d] fwd/err: got %b/%b want %b/%b",
                         i, fwd, mem_timeout_err, f, r);
            end
        end
        n_chk++;
        if (perf_stall_cnt !== 32'(exp_perf)) begin
            n_fail++;
            $display("FAIL timeout perf: got %0d want %0d",
                     perf_stall_cnt, exp_perf);
        end
        @(negedge clk);
        apply(mk(1,5, 0,0, 1,5,1, 0,0, 1,0,1));
        #2;
        rst = 1'b0;
        exp_perf = 0;
        #1;
        n_chk++;
        if (comb !== 5'b00000 || fwd !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_rst comb/fwd: got %b/%b want 00000/0000",
                     comb, fwd);
        end
        n_chk++;
        if (mem_timeout_err !== 1'b0 || perf_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL async_rst err/perf: got %b/%0d want 0/0",
                     mem_timeout_err, perf_stall_cnt);
        end
        @(posedge clk);
        #1;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        logic [4:0] e;
        logic       r;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            apply(mk(0,0, 0,0, 0,0,0, 0,0, 1,0,0));
            comb_q.push_back(5'b11100);
            exp_perf++;
            #1;
            e = comb_q.pop_front();
            n_chk++;
            if (comb !== e) begin
                n_fail++;
                $display("FAIL mid_wait pre[%0d] comb: got %b want %b", k, comb, e);
            end
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_perf = 0;
        #1;
        n_chk++;
        if (comb !== 5'b00000 || perf_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_wait rst: comb %b perf %0d want 00000/0",
                     comb, perf_stall_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            apply(mk(0,0, 0,0, 0,0,0, 0,0, 1,0,0));
            err_q.push_back(k == 5);
            exp_perf++;
            @(posedge clk);
            #1;
            r = err_q.pop_front();
            n_chk++;
            if (mem_timeout_err !== r) begin
                n_fail++;
                $display("FAIL mid_wait err[%0d]: got %b want %b",
                         k, mem_timeout_err, r);
            end
        end
        n_chk++;
        if (perf_stall_cnt !== 32'(exp_perf)) begin
            n_fail++;
            $display("FAIL mid_wait perf: got %0d want %0d",
                     perf_stall_cnt, exp_perf);
        end
        @(negedge clk);
        apply(mk(0,0,0,0,0,0,0,0,0,0,1,0));
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        exp_perf = 0;
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_redirect();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
